// File: rtl/tqv_harness_pkg.sv
// Shared constants for the TinyQV-style SPI peripheral harness: frame layout,
// special addresses and bidirectional pin assignments.
package tqv_harness_pkg;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned DATA_BITS = 32;

  localparam logic [5:0] ADDR_UI_IN   = 6'h3F;
  localparam logic [7:0] UIO_OE_VALUE = 8'h08;

  localparam int unsigned PIN_CS_N = 0;
  localparam int unsigned PIN_SCK  = 1;
  localparam int unsigned PIN_MOSI = 2;
  localparam int unsigned PIN_MISO = 3;

endpackage

// File: rtl/tqv_harness_if.sv
// Register-access bus between the SPI command decoder (master) and the
// register bank (slave).
interface tqv_harness_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [31:0]       wr_data;
  logic              wr_strobe;
  logic              rd_latch;
  logic [31:0]       rd_data;

  modport master (
    output addr, rw, wr_data, wr_strobe, rd_latch,
    input  rd_data
  );

  modport slave (
    input  addr, rw, wr_data, wr_strobe, rd_latch,
    output rd_data
  );
endinterface

// File: rtl/tqv_spi_slave.sv
// Mode-0 SPI slave: synchronizes the pins, frames 8 command + 32 data bits and
// turns them into register-bus write strobes and read-latch requests.
module tqv_spi_slave
  import tqv_harness_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  tqv_harness_if.master bus
);

  localparam logic [5:0] CntCmdLast = 6'(CMD_BITS - 1);
  localparam logic [5:0] CntLast    = 6'(CMD_BITS + DATA_BITS - 1);
  localparam logic [5:0] CntEnd     = 6'(CMD_BITS + DATA_BITS);

  logic [1:0]        cs_q, sck_q, mosi_q;
  logic              sck_prev_q;
  logic [5:0]        cnt_q;
  logic [ADDR_W:0]   cmd_q;  // {rw, addr}; command bit 0 is never stored
  logic [31:0]       data_q;
  logic [31:0]       rd_q;
  logic              miso_q;

  logic cs_n_s, mosi_s, rise, fall, rd_latch, rd_phase;

  always_comb begin
    cs_n_s   = cs_q[1];
    mosi_s   = mosi_q[1];
    rise     = sck_q[1] & ~sck_prev_q;
    fall     = ~sck_q[1] & sck_prev_q;
    rd_latch = rise && !cs_n_s && (cnt_q == CntCmdLast) && !cmd_q[ADDR_W];
    rd_phase = !cmd_q[ADDR_W] && (cnt_q >= 6'(CMD_BITS)) && (cnt_q < CntEnd);
  end

  // The 40th edge commits even if cs_n rises in the same synchronized cycle.
  assign bus.wr_strobe = rise && (cnt_q == CntLast) && cmd_q[ADDR_W];
  assign bus.wr_data   = {data_q[30:0], mosi_s};
  assign bus.addr      = cmd_q[ADDR_W-1:0];
  assign bus.rw        = cmd_q[ADDR_W];
  assign bus.rd_latch  = rd_latch;
  assign miso          = miso_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q       <= 2'b11;
      sck_q      <= 2'b00;
      mosi_q     <= 2'b00;
      sck_prev_q <= 1'b0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      miso_q     <= 1'b0;
    end else begin
      cs_q       <= {cs_q[0], cs_n};
      sck_q      <= {sck_q[0], sck};
      mosi_q     <= {mosi_q[0], mosi};
      sck_prev_q <= sck_q[1];
      if (cs_n_s) begin
        cnt_q  <= '0;
        cmd_q  <= '0;
        data_q <= '0;
        rd_q   <= '0;
        miso_q <= 1'b0;
      end else begin
        if (rise && cnt_q < CntEnd) begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q < CntCmdLast) begin
            cmd_q <= {cmd_q[ADDR_W-1:0], mosi_s};
          end else if (cnt_q > CntCmdLast) begin
            data_q <= {data_q[30:0], mosi_s};
          end
        end
        if (rd_latch) begin
          rd_q <= bus.rd_data;
        end else if (fall) begin
          if (rd_phase) begin
            miso_q <= rd_q[31];
            rd_q   <= {rd_q[30:0], 1'b0};
          end else begin
            miso_q <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tt_um_tqv_peripheral_harness.sv
// Tiny Tapeout harness: SPI slave on the uio pins fronting a bank of 32-bit
// read/write registers; reg 0 low byte drives uo_out, ui_in readable at 0x3F.
module tt_um_tqv_peripheral_harness
  import tqv_harness_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  tqv_harness_if #(.ADDR_W(ADDR_W)) bus ();

  logic        miso;
  logic [31:0] regs_q [NUM_REGS];
  logic        addr_in_bank;
  logic        unused;

  tqv_spi_slave #(
    .ADDR_W(ADDR_W)
  ) u_spi (
    .clk   (clk),
    .rst_n (rst_n),
    .cs_n  (uio_in[PIN_CS_N]),
    .sck   (uio_in[PIN_SCK]),
    .mosi  (uio_in[PIN_MOSI]),
    .miso  (miso),
    .bus   (bus.master)
  );

  assign addr_in_bank = 32'(bus.addr) < NUM_REGS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wr_strobe && addr_in_bank) begin
      regs_q[bus.addr[IdxW-1:0]] <= bus.wr_data;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (addr_in_bank) begin
      bus.rd_data = regs_q[bus.addr[IdxW-1:0]];
    end else if (bus.addr == ADDR_UI_IN) begin
      bus.rd_data = {24'h0, ui_in};
    end
  end

  always_comb begin
    uio_out           = '0;
    uio_out[PIN_MISO] = miso;
  end

  assign uo_out = regs_q[0][7:0];
  assign uio_oe = UIO_OE_VALUE;

  assign unused = ^{ena, uio_in[7:3], bus.rd_latch, bus.rw};

endmodule

// File: tb/tb_tt_um_tqv_peripheral_harness.sv
// Self-checking bench: drives SPI frames on uio_in and compares reads, uo_out
// and idle pin values against a register-array model of the peripheral.
module tb_tt_um_tqv_peripheral_harness;

  localparam int HALF = 4;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_in, uio_out, uio_oe;
  logic       cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;

  assign uio_in = {5'b0, mosi, sck, cs_n};

  always #5 clk = ~clk;

  tt_um_tqv_peripheral_harness dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [16];

  function automatic logic [31:0] exp_read(input logic [5:0] addr);
    if (addr < 6'd16) return model[addr[3:0]];
    if (addr == 6'h3F) return {24'h0, ui_in};
    return 32'h0;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  // rises < 40 cuts the frame short; rst_at_stop pulses rst_n at the cut point.
  task automatic spi_xfer(input logic rw, input logic [5:0] addr, input logic [31:0] wdata,
                          input int rises, input bit rst_at_stop, output logic [31:0] rdata);
    logic [39:0] frame;
    frame = {rw, addr, 1'b0, wdata};
    rdata = 32'h0;
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < rises; i++) begin
      mosi = frame[39-i];
      wait_clk(HALF);
      if (i >= 8) rdata[39-i] = uio_out[3];
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    if (rst_at_stop) begin
      rst_n = 1'b0;
      wait_clk(3);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    spi_xfer(1'b1, addr, data, 40, 1'b0, dummy);
    if (addr < 6'd16) model[addr[3:0]] = data;
  endtask

  task automatic do_read(input logic [5:0] addr, output logic [31:0] data);
    spi_xfer(1'b0, addr, 32'h0, 40, 1'b0, data);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    wait_clk(10);
    rst_n = 1'b1;
    wait_clk(2);
    model_clear();
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_uo_out: got %h want 00", uo_out);
    end
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_uio_out: got %h want 00", uio_out);
    end
    n_checks++;
    if (uio_oe !== 8'h08) begin
      n_fail++; $display("FAIL reset_uio_oe: got %h want 08", uio_oe);
    end
    do_read(6'd0, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_read0: got %h want 00000000", rd);
    end
  endtask

  task automatic test_write_readback();
    logic [31:0] rd;
    do_write(6'd0, 32'hDEADBEEF);
    n_checks++;
    if (uo_out !== 8'hEF) begin
      n_fail++; $display("FAIL wr_uo_out: got %h want ef", uo_out);
    end
    do_read(6'd0, rd);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_readback0: got %h want deadbeef", rd);
    end
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++; $display("FAIL idle_miso: got %h want 00", uio_out);
    end
  endtask

  task automatic test_reg_independence();
    logic [31:0] rd;
    logic [5:0]  addrs [3];
    addrs[0] = 6'd5; addrs[1] = 6'd15; addrs[2] = 6'd0;
    do_write(6'd5, 32'h12345678);
    do_write(6'd15, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], rd);
      n_checks++;
      if (rd !== exp_read(addrs[i])) begin
        n_fail++;
        $display("FAIL indep_read[%0d]: got %h want %h", addrs[i], rd, exp_read(addrs[i]));
      end
    end
  endtask

  task automatic test_ui_in();
    logic [31:0] rd;
    ui_in = 8'h5A;
    do_read(6'h3F, rd);
    n_checks++;
    if (rd !== 32'h0000005A) begin
      n_fail++; $display("FAIL ui_in_read: got %h want 0000005a", rd);
    end
    do_write(6'h3F, 32'hFFFFFFFF);
    do_read(6'h3F, rd);
    n_checks++;
    if (rd !== 32'h0000005A) begin
      n_fail++; $display("FAIL ui_in_after_write: got %h want 0000005a", rd);
    end
    do_write(6'h20, 32'h13579BDF);
    do_read(6'h20, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read: got %h want 00000000", rd);
    end
    n_checks++;
    if (uo_out !== model[0][7:0]) begin
      n_fail++; $display("FAIL unmapped_uo_out: got %h want %h", uo_out, model[0][7:0]);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    do_write(6'd1, 32'h0BADF00D);
    spi_xfer(1'b1, 6'd1, 32'hFFFFFFFF, 8 + 20, 1'b0, rd);
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++; $display("FAIL abort_miso: got %h want 00", uio_out);
    end
    do_read(6'd1, rd);
    n_checks++;
    if (rd !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL abort_read1: got %h want 0badf00d", rd);
    end
    // Aborted read: next full read must still be clean.
    spi_xfer(1'b0, 6'd1, 32'h0, 8 + 5, 1'b0, rd);
    do_read(6'd5, rd);
    n_checks++;
    if (rd !== model[5]) begin
      n_fail++; $display("FAIL abort_read_then_read5: got %h want %h", rd, model[5]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    spi_xfer(1'b1, 6'd0, 32'h0F0F0F0F, 8 + 10, 1'b1, rd);
    model_clear();
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_fail++; $display("FAIL midrst_uo_out: got %h want 00", uo_out);
    end
    do_read(6'd15, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL midrst_read15: got %h want 00000000", rd);
    end
    do_write(6'd0, 32'h000000C3);
    n_checks++;
    if (uo_out !== 8'hC3) begin
      n_fail++; $display("FAIL midrst_rewrite_uo: got %h want c3", uo_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, data;
    logic [5:0]  addr;
    for (int i = 0; i < 40; i++) begin
      ui_in = 8'($urandom);
      addr  = ($urandom_range(0, 9) < 7) ? 6'($urandom_range(0, 15)) : 6'($urandom);
      data  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(addr, data);
      end else begin
        do_read(addr, rd);
        n_checks++;
        if (rd !== exp_read(addr)) begin
          n_fail++;
          $display("FAIL rand_read[%0d] addr %h: got %h want %h", i, addr, rd, exp_read(addr));
        end
      end
      n_checks++;
      if (uo_out !== model[0][7:0]) begin
        n_fail++; $display("FAIL rand_uo_out[%0d]: got %h want %h", i, uo_out, model[0][7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_reg_independence();
    test_ui_in();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
